// File: rtl/instr_encoder_loader.sv
// Purpose:      encodes symbolic instruction requests into 16-bit words and streams them to instruction memory.
// Latency:      request accepted at edge N (empty FIFO, idle write stage) -> o_mem_wr high after edge N+1.
// Backpressure: i_mem_wait holds the registered write stage; the FIFO fills and o_ready (registered) drops.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_start / i_end                 session start / end pulses
//   i_valid, o_ready                request handshake; i_opcode, i_rx, i_ry, i_imm request fields
//   o_mem_wr, o_mem_addr,
//   o_mem_wdata, i_mem_wait         stallable memory write port
//   o_busy, o_done, o_err, o_count  session status
module instr_encoder_loader #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_end,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [4:0]        i_opcode,
    input  logic [2:0]        i_rx,
    input  logic [2:0]        i_ry,
    input  logic [10:0]       i_imm,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    input  logic              i_mem_wait,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [15:0]       enc;
    logic              legal;
    logic              accept;
    logic              push;
    logic              pop;
    logic              wr_cmpl;
    logic              start_ok;
    logic              ready_nxt;
    logic [ADDR_W-1:0] addr;

    // FIFO storage; pointers carry one extra bit so full and empty differ.
    logic [15:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] fifo_cnt, cnt_nxt;
    logic        fifo_empty;

    assign accept     = i_valid && o_ready;
    assign push       = accept && legal;
    assign wr_cmpl    = o_mem_wr && !i_mem_wait;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_cnt   = wr_ptr - rd_ptr;
    // The write stage takes a new word when empty or when its word leaves this cycle.
    assign pop        = (!o_mem_wr || wr_cmpl) && !fifo_empty;
    assign start_ok   = (state == S_IDLE) && i_start;
    assign cnt_nxt    = fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
    // Registered ready: computed from next-cycle occupancy so it never lets a push overflow.
    assign ready_nxt  = (state_nxt == S_LOAD) && (cnt_nxt < DEPTH_CNT);
    assign o_busy     = (state != S_IDLE);
    // Address is only meaningful with a write; hold it at zero otherwise so reset reads 0.
    assign o_mem_addr = o_mem_wr ? addr : '0;

    // Field packing and legality of the incoming request.
    always_comb begin
        enc      = '0;
        legal    = 1'b0;
        enc[4:0] = i_opcode;
        case (i_opcode[4:3])
            2'b00: begin
                enc[7:5]  = i_rx;
                enc[10:8] = i_ry;
                legal     = (i_opcode[2:0] <= 3'd5);
            end
            2'b01: begin
                enc[7:5] = i_rx;
                legal    = i_opcode[2:0] inside {3'd0, 3'd1, 3'd2, 3'd4};
            end
            2'b10: begin
                enc[7:5]  = i_rx;
                enc[15:8] = i_imm[7:0];
                // immediate must fit a signed 8-bit field
                legal     = (i_opcode[2:0] inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6})
                            && (i_imm[10:8] == {3{i_imm[7]}});
            end
            default: begin
                enc[15:5] = i_imm;
                legal     = i_opcode[2:0] inside {3'd0, 3'd1, 3'd2, 3'd4};
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        o_done    = 1'b0;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_LOAD;
            S_LOAD:  if (i_end) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (fifo_empty && !o_mem_wr) begin
                    state_nxt = S_IDLE;
                    o_done    = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[AW-1:0]] <= enc;
                wr_ptr                   <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_ready     <= 1'b0;
            o_mem_wr    <= 1'b0;
            o_mem_wdata <= '0;
            addr        <= BASE_ADDR;
            o_count     <= '0;
            o_err       <= 1'b0;
        end else begin
            o_ready <= ready_nxt;
            if (start_ok) begin
                addr    <= BASE_ADDR;
                o_count <= '0;
                o_err   <= 1'b0;
            end else begin
                if (wr_cmpl) begin
                    addr    <= addr + ADDR_W'(2);
                    o_count <= o_count + ADDR_W'(1);
                end
                if (accept && !legal) begin
                    o_err <= 1'b1;
                end
            end
            if (pop) begin
                o_mem_wr    <= 1'b1;
                o_mem_wdata <= fifo_mem[rd_ptr[AW-1:0]];
            end else if (wr_cmpl) begin
                o_mem_wr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Purpose: randomized and directed checks of instr_encoder_loader against a word-list reference model.
// Two instances share stimulus: base 0x0000 and base 0xFFFC (address wrap).
// Ports: none (top-level bench).
module tb_instr_encoder_loader;

    localparam int N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        i_start;
    logic        i_end;
    logic        i_valid;
    logic        mem_wait;
    logic [4:0]  opcode;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [10:0] imm;

    logic        ready    [N];
    logic        mem_wr   [N];
    logic [15:0] mem_addr [N];
    logic [15:0] wdata    [N];
    logic        busy     [N];
    logic        done     [N];
    logic        err      [N];
    logic [15:0] count    [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        instr_encoder_loader #(
            .ADDR_W    (16),
            .BASE_ADDR (g == 0 ? 16'h0000 : 16'hFFFC),
            .FIFO_DEPTH(4)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .i_start    (i_start),
            .i_end      (i_end),
            .i_valid    (i_valid),
            .o_ready    (ready[g]),
            .i_opcode   (opcode),
            .i_rx       (rx),
            .i_ry       (ry),
            .i_imm      (imm),
            .o_mem_wr   (mem_wr[g]),
            .o_mem_addr (mem_addr[g]),
            .o_mem_wdata(wdata[g]),
            .i_mem_wait (mem_wait),
            .o_busy     (busy[g]),
            .o_done     (done[g]),
            .o_err      (err[g]),
            .o_count    (count[g])
        );
    end

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q [$];
    bit          exp_err = 1'b0;
    int          sess_gen = 0;
    int          idx [N];
    int          wait_mode = 0;
    int          acc_cnt = 0;
    int          lat = 0;
    int          nb2b = 0;
    int          nreq = 0;
    int          legal_ops [19] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 12, 16, 17, 18, 19, 22, 24, 25, 26, 28};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] base_of(input int g);
        return (g == 0) ? 16'h0000 : 16'hFFFC;
    endfunction

    // Reference: legality from the opcode table and the signed immediate range.
    function automatic bit model_legal(input int op, input int im);
        bit in_list = 1'b0;
        int v;
        foreach (legal_ops[i]) if (legal_ops[i] == op) in_list = 1'b1;
        v = (im >= 1024) ? im - 2048 : im;
        if (op / 8 == 2) return in_list && (v >= -128) && (v <= 127);
        return in_list;
    endfunction

    // Reference: instruction word built arithmetically from the field positions.
    function automatic int model_word(input int op, input int x, input int y, input int im);
        case (op / 8)
            0:       return op + x * 32 + y * 256;
            1:       return op + x * 32;
            2:       return op + x * 32 + (im % 256) * 256;
            default: return op + im * 32;
        endcase
    endfunction

    task automatic monitor();
        int          gen_seen = 0;
        logic [15:0] ea;
        for (int g = 0; g < N; g++) idx[g] = 0;
        forever begin
            @(negedge clk);
            if (gen_seen != sess_gen) begin
                gen_seen = sess_gen;
                for (int g = 0; g < N; g++) idx[g] = 0;
            end
            if (!reset) begin
                for (int g = 0; g < N; g++) begin
                    if (mem_wr[g]) begin
                        // Every cycle a write is presented (stalled or not) it must be the next word.
                        if (idx[g] < exp_q.size()) begin
                            ea = base_of(g) + 16'(2 * idx[g]);
                            chk($sformatf("wdata%0d[%0d]", g, idx[g]), wdata[g], exp_q[idx[g]]);
                            chk($sformatf("addr%0d[%0d]", g, idx[g]), mem_addr[g], ea);
                        end else begin
                            chk($sformatf("extra_wr%0d", g), idx[g] + 1, exp_q.size());
                        end
                        if (!mem_wait) idx[g]++;
                    end
                end
            end
        end
    endtask

    task automatic wait_gen();
        forever begin
            @(posedge clk);
            #2;
            case (wait_mode)
                0:       mem_wait = 1'b0;
                1:       mem_wait = 1'b1;
                default: mem_wait = ($urandom_range(0, 3) == 0);
            endcase
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [4:0] op, input logic [2:0] x, input logic [2:0] y,
                        input logic [10:0] im, input bit with_end);
        int t = 0;
        int o = op;
        int iv = im;
        opcode  = op;
        rx      = x;
        ry      = y;
        imm     = im;
        i_valid = 1'b1;
        @(negedge clk);
        while (!ready[0] && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!ready[0]) begin
            chk("accept_timeout", ready[0], 1);
        end else begin
            acc_cnt++;
            if (model_legal(o, iv)) exp_q.push_back(16'(model_word(o, int'(x), int'(y), iv)));
            else exp_err = 1'b1;
            if (with_end) i_end = 1'b1;
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_end   = 1'b0;
    endtask

    task automatic rand_req(input bit with_end);
        logic [4:0]  op;
        logic [10:0] im;
        if ($urandom_range(0, 3) != 0) op = 5'(legal_ops[$urandom_range(0, 18)]);
        else op = 5'($urandom_range(0, 31));
        im = 11'($urandom);
        if (op[4:3] == 2'b10 && $urandom_range(0, 3) != 0) im = 11'($urandom_range(0, 255)) - 11'd128;
        send(op, 3'($urandom), 3'($urandom), im, with_end);
    endtask

    task automatic start_sess();
        i_start = 1'b1;
        exp_q.delete();
        exp_err = 1'b0;
        sess_gen++;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(negedge clk);
        chk("start_busy", busy[0], 1);
        chk("start_err", err[0], 0);
        chk("start_cnt", count[0], 0);
        chk("start_rdy", ready[0], 1);
        @(posedge clk);
        #1;
    endtask

    task automatic end_sess();
        i_end = 1'b1;
        @(posedge clk);
        #1;
        i_end = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        @(negedge clk);
        while (!done[0] && l < 200) begin
            @(negedge clk);
            l++;
        end
        chk("done_seen", done[0], 1);
        chk("done_seen1", done[1], 1);
        chk("done_busy", busy[0], 1);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("done_cnt%0d", g), count[g], exp_q.size());
            chk($sformatf("done_nwr%0d", g), idx[g], exp_q.size());
            chk($sformatf("done_err%0d", g), err[g], exp_err);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("done_pulse", done[0], 0);
        chk("done_idle", busy[0], 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        sess_gen++;
        exp_q.delete();
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        i_start  = 1'b0;
        i_end    = 1'b0;
        i_valid  = 1'b0;
        mem_wait = 1'b0;
        opcode   = '0;
        rx       = '0;
        ry       = '0;
        imm      = '0;
        fork
            monitor();
            wait_gen();
            begin
                repeat (30000) @(posedge clk);
                $display("FAIL watchdog: cycle budget exhausted, got busy=%0d expected idle", busy[0]);
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("rst_rdy%0d", g), ready[g], 0);
            chk($sformatf("rst_busy%0d", g), busy[g], 0);
            chk($sformatf("rst_done%0d", g), done[g], 0);
            chk($sformatf("rst_err%0d", g), err[g], 0);
            chk($sformatf("rst_cnt%0d", g), count[g], 0);
            chk($sformatf("rst_wr%0d", g), mem_wr[g], 0);
            chk($sformatf("rst_addr%0d", g), mem_addr[g], 0);
        end
        @(posedge clk);
        #1;

        // mv then addi, with first-write latency
        start_sess();
        send(5'b00000, 3'd1, 3'd2, 11'd0, 1'b0);
        @(negedge clk);
        chk("lat_n", mem_wr[0], 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_n1", mem_wr[0], 1);
        @(posedge clk);
        #1;
        send(5'b10001, 3'd3, 3'd0, 11'd5, 1'b0);
        cycles(4);
        end_sess();
        wait_done(lat);
        chk("done_latency", lat, 0);

        // negative immediates
        start_sess();
        send(5'b11000, 3'd0, 3'd0, 11'h7FE, 1'b0);
        send(5'b10000, 3'd0, 3'd0, 11'h7FF, 1'b0);
        end_sess();
        wait_done(lat);

        // illegal requests, then a legal cmp at the base address
        start_sess();
        send(5'b00110, 3'd1, 3'd1, 11'd0, 1'b0);
        send(5'b10001, 3'd3, 3'd0, 11'h080, 1'b0);
        cycles(3);
        @(negedge clk);
        chk("ill_nowr", idx[0], 0);
        chk("ill_wr", mem_wr[0], 0);
        chk("ill_err", err[0], 1);
        @(posedge clk);
        #1;
        send(5'b00011, 3'd1, 3'd1, 11'd0, 1'b0);
        end_sess();
        wait_done(lat);

        // backpressure: ten stalled cycles with six requests offered
        wait_mode = 1;
        start_sess();
        acc_cnt = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) rand_req(1'b0);
            end
            begin
                repeat (10) @(negedge clk);
                chk("bp_accepted", acc_cnt, 5);
                chk("bp_ready", ready[0], 0);
                chk("bp_cnt", count[0], 0);
                @(posedge clk);
                #1;
                wait_mode = 0;
                nb2b = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (mem_wr[0] && !mem_wait) nb2b++;
                end
                chk("bp_b2b", nb2b, 6);
            end
        join
        end_sess();
        wait_done(lat);

        // three writes; instance 1 wraps 0xFFFC, 0xFFFE, 0x0000
        wait_mode = 2;
        start_sess();
        for (int k = 0; k < 3; k++) send(5'b00001, 3'(k), 3'(k + 1), 11'd0, 1'b0);
        end_sess();
        wait_done(lat);

        // reset with words queued behind a stalled write
        wait_mode = 1;
        start_sess();
        for (int k = 0; k < 4; k++) send(5'b00010, 3'(k), 3'd7, 11'd0, 1'b0);
        pulse_reset();
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("mrst_wr%0d", g), mem_wr[g], 0);
            chk($sformatf("mrst_busy%0d", g), busy[g], 0);
            chk($sformatf("mrst_rdy%0d", g), ready[g], 0);
        end
        @(posedge clk);
        #1;
        wait_mode = 0;
        cycles(8);
        chk("mrst_nowr", idx[0], 0);

        // start during DRAIN must be ignored (err stays, no return to LOAD)
        wait_mode = 1;
        start_sess();
        send(5'b00111, 3'd0, 3'd0, 11'd0, 1'b0);
        send(5'b01000, 3'd5, 3'd0, 11'd0, 1'b0);
        end_sess();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(negedge clk);
        chk("drain_busy", busy[0], 1);
        chk("drain_rdy", ready[0], 0);
        chk("drain_err", err[0], 1);
        @(posedge clk);
        #1;
        wait_mode = 0;
        wait_done(lat);

        // randomized sessions with random memory stalls
        for (int s = 0; s < 6; s++) begin
            wait_mode = 2;
            start_sess();
            nreq = $urandom_range(4, 16);
            for (int k = 0; k < nreq; k++) begin
                rand_req((s % 2 == 0) && (k == nreq - 1));
                if (k < nreq - 1) cycles($urandom_range(0, 2));
            end
            if (s % 2 != 0) end_sess();
            wait_done(lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
